// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared FSM states, LCD instruction constants and line limits
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT_LO,
    WAIT_HI,
    CHAR,
    DONE
  } lcd_state_t;

  localparam logic [7:0] LCD_INS_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_INS_CLEAR     = 8'h01;
  localparam int         LCD_LINE_MAX      = 16;

  // Set-DDRAM instruction for a 7-bit cursor address
  function automatic logic [7:0] lcd_ddram_cmd(input logic [6:0] addr);
    return LCD_INS_SET_DDRAM | {1'b0, addr};
  endfunction

endpackage

// File: rtl/lcd_line_arb.sv
// rtl/lcd_line_arb.sv - two-requester line arbiter; LCD_RR_ARB_EN selects round-robin over fixed priority
module lcd_line_arb (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt
);

  // Requester that wins when both are asking
  logic fav;

`ifdef LCD_RR_ARB_EN
  assign fav = prio;
`else
  assign fav = 1'b0 & prio;
`endif

  // One-hot grant; nothing is granted unless the scheduler is ready to start a line
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = fav ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/lcd_line_scheduler.sv
// rtl/lcd_line_scheduler.sv - shares the LCD write port between two line requesters; LCD_RR_ARB_EN enables round-robin
module lcd_line_scheduler
  import lcd_pkg::*;
#(
  parameter int         LINE_LEN   = LCD_LINE_MAX,
  parameter logic [7:0] ADDR_LINE0 = lcd_ddram_cmd(7'h00),
  parameter logic [7:0] ADDR_LINE1 = lcd_ddram_cmd(7'h40)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] char_in0,
  input  logic [7:0] char_in1,
  output logic [3:0] char_idx,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  input  logic       lcd_ready,
  output logic       lcd_send,
  output logic       lcd_ins_data,
  output logic [7:0] lcd_data
);

  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

  lcd_state_t state, state_nxt;
  logic [1:0] gnt_nxt;
  logic [1:0] arb_gnt;
  logic [3:0] idx_nxt;
  logic       send_nxt;
  logic       rs_nxt;
  logic [7:0] data_nxt;
  logic       prio;
  logic       arb_en;

  assign arb_en = (state == IDLE) && lcd_ready;

  lcd_line_arb u_arb (
    .req  (req),
    .prio (prio),
    .en   (arb_en),
    .gnt  (arb_gnt)
  );

`ifdef LCD_RR_ARB_EN
  // Favour the requester that was not served by the line just finished
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 1'b0;
    end else if (state == DONE) begin
      prio <= gnt[0];
    end
  end
`else
  assign prio = 1'b0;
`endif

  // Next state and next values of the registered LCD outputs
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    idx_nxt   = char_idx;
    send_nxt  = 1'b0;
    rs_nxt    = lcd_ins_data;
    data_nxt  = lcd_data;
    case (state)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          gnt_nxt   = arb_gnt;
          state_nxt = CMD;
        end
      end
      CMD: begin
        data_nxt  = gnt[1] ? ADDR_LINE1 : ADDR_LINE0;
        rs_nxt    = 1'b0;
        send_nxt  = 1'b1;
        state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!lcd_ready) begin
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (lcd_ready) begin
          // RS still low means the write that just finished was the cursor instruction
          if (!lcd_ins_data) begin
            idx_nxt   = 4'd0;
            state_nxt = CHAR;
          end else if (char_idx < LAST_IDX) begin
            idx_nxt   = char_idx + 4'd1;
            state_nxt = CHAR;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      CHAR: begin
        data_nxt  = gnt[1] ? char_in1 : char_in0;
        rs_nxt    = 1'b1;
        send_nxt  = 1'b1;
        state_nxt = WAIT_LO;
      end
      DONE: begin
        gnt_nxt   = 2'b00;
        idx_nxt   = 4'd0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = 2'b00;
        idx_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant, index and LCD bus registers; send/data/RS all move on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      gnt          <= 2'b00;
      char_idx     <= 4'd0;
      lcd_send     <= 1'b0;
      lcd_ins_data <= 1'b0;
      lcd_data     <= 8'h00;
    end else begin
      state        <= state_nxt;
      gnt          <= gnt_nxt;
      char_idx     <= idx_nxt;
      lcd_send     <= send_nxt;
      lcd_ins_data <= rs_nxt;
      lcd_data     <= data_nxt;
    end
  end

  assign done = (state == DONE) ? gnt : 2'b00;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// tb/tb_lcd_line_scheduler.sv - self-checking bench for lcd_line_scheduler
module tb_lcd_line_scheduler;

  localparam int LINE_LEN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] char_in0;
  logic [7:0] char_in1;
  logic [3:0] char_idx;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       lcd_ready = 1'b1;
  logic       lcd_send;
  logic       lcd_ins_data;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  assign char_in0 = 8'h30 + {4'h0, char_idx};
  assign char_in1 = 8'h41 + {4'h0, char_idx};

  lcd_line_scheduler #(.LINE_LEN(LINE_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .char_in0     (char_in0),
    .char_in1     (char_in1),
    .char_idx     (char_idx),
    .gnt          (gnt),
    .done         (done),
    .busy         (busy),
    .lcd_ready    (lcd_ready),
    .lcd_send     (lcd_send),
    .lcd_ins_data (lcd_ins_data),
    .lcd_data     (lcd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_bytes[$];
  int         exp_lines[$];
  int         total_sends = 0;
  int         bytes_in_line = 0;
  bit         prev_send = 0;
  int         busy_cnt = 0;
  bit         force_low = 0;
  bit         model_prio = 0;
  logic [8:0] cur_exp;
  int         cur_line;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [7:0] model_char(input int g, input int i);
    return (g == 0) ? 8'(8'h30 + i) : 8'(8'h41 + i);
  endfunction

  function automatic int model_pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef LCD_RR_ARB_EN
    return model_prio ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [1:0] onehot(input int g);
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  // Expected writes for one complete line granted to requester g
  task automatic push_line(input int g);
    exp_lines.push_back(g);
    exp_bytes.push_back({1'b0, (g == 0) ? 8'h80 : 8'hC0});
    for (int i = 0; i < LINE_LEN; i++) exp_bytes.push_back({1'b1, model_char(g, i)});
    model_prio = (g == 0);
  endtask

  // LCD interface model: ready drops one cycle after a send, stays low 10 cycles
  initial forever begin
    @(negedge clk);
    if (!rst) busy_cnt = 0;
    else if (lcd_send) busy_cnt = 11;
    else if (busy_cnt > 0) busy_cnt--;
    lcd_ready = !force_low && !(busy_cnt >= 1 && busy_cnt <= 10);
  end

  // Per-cycle comparison of the DUT against the expected write stream
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_send     = 0;
      bytes_in_line = 0;
    end else begin
      check_eq("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      check_eq("busy_vs_gnt", 32'(busy), 32'(gnt != 2'b00));
      if (lcd_send) begin
        total_sends++;
        bytes_in_line++;
        check_eq("send_single_cycle", 32'(prev_send), 32'd0);
        if (exp_bytes.size() == 0) begin
          fail_now("send_without_expected_byte");
        end else begin
          cur_exp = exp_bytes.pop_front();
          check_eq("lcd_byte", 32'({lcd_ins_data, lcd_data}), 32'(cur_exp));
        end
        if (exp_lines.size() > 0) check_eq("gnt_during_send", 32'(gnt), 32'(onehot(exp_lines[0])));
      end
      if (done != 2'b00) begin
        if (exp_lines.size() == 0) begin
          fail_now("done_without_expected_line");
        end else begin
          cur_line = exp_lines.pop_front();
          check_eq("done_bit", 32'(done), 32'(onehot(cur_line)));
          check_eq("line_byte_count", bytes_in_line, 1 + LINE_LEN);
        end
        bytes_in_line = 0;
      end
      prev_send = lcd_send;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req       = 2'b00;
    force_low = 0;
    exp_bytes.delete();
    exp_lines.delete();
    model_prio = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now({name, "_done_timeout"});
  endtask

  task automatic wait_first_send(input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (lcd_send) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now({name, "_send_timeout"});
  endtask

  task automatic wait_sends(input int target, input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (total_sends >= target) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now({name, "_sends_timeout"});
  endtask

  initial begin
    int start;
    int extra_done;
    int bad;
    int order[4];
    logic [3:0] order_v;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_send", 32'(lcd_send), 32'd0);
    check_eq("rst_rs", 32'(lcd_ins_data), 32'd0);
    check_eq("rst_data", 32'(lcd_data), 32'h00);
    check_eq("rst_idx", 32'(char_idx), 32'd0);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single requester 0, full line, timing of grant and CMD
    push_line(0);
    check_eq("model_len", exp_bytes.size(), 17);
    check_eq("model_first", 32'(exp_bytes[0]), 32'h080);
    check_eq("model_last", 32'(exp_bytes[16]), 32'h13F);
    start = total_sends;
    req = 2'b01;
    @(negedge clk);
    check_eq("t1_gnt_next_cycle", 32'(gnt), 32'h1);
    check_eq("t1_no_send_yet", 32'(lcd_send), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t1_cmd_send", 32'(lcd_send), 32'd1);
    check_eq("t1_cmd_byte", 32'(lcd_data), 32'h80);
    check_eq("t1_cmd_rs", 32'(lcd_ins_data), 32'd0);
    wait_done("t1");
    req = 2'b00;
    extra_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done != 2'b00) extra_done++;
    end
    check_eq("t1_done_once", extra_done, 0);
    check_eq("t1_send_total", total_sends - start, 17);
    check_eq("t1_idle_busy", 32'(busy), 32'd0);

    // Both requesting: four lines
    do_reset();
    for (int i = 0; i < 4; i++) begin
      order[i] = model_pick(2'b11);
      push_line(order[i]);
    end
    order_v = {order[0][0], order[1][0], order[2][0], order[3][0]};
`ifdef LCD_RR_ARB_EN
    check_eq("t2_model_order", 32'(order_v), 32'b0101);
`else
    check_eq("t2_model_order", 32'(order_v), 32'b0000);
`endif
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_done("t2");
    req = 2'b00;
    repeat (5) @(negedge clk);

    // Ready held low: nothing may start
    do_reset();
    force_low = 1;
    lcd_ready = 1'b0;
    req = 2'b10;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (lcd_send || gnt != 2'b00 || busy) bad++;
    end
    check_eq("t4_stalled", bad, 0);
    push_line(1);
    force_low = 0;
    wait_first_send("t4");
    check_eq("t4_cmd_byte", 32'(lcd_data), 32'hC0);
    check_eq("t4_cmd_rs", 32'(lcd_ins_data), 32'd0);
    wait_done("t4");
    req = 2'b00;
    repeat (5) @(negedge clk);

    // Asynchronous reset in WAIT_HI of char 5, then fresh request
    do_reset();
    push_line(0);
    start = total_sends;
    req = 2'b01;
    wait_sends(start + 7, "t5");
    repeat (5) @(negedge clk);
    check_eq("t5_mid_idx", 32'(char_idx), 32'd5);
    #2 rst = 1'b0;
    #1;
    check_eq("t5_async_send", 32'(lcd_send), 32'd0);
    check_eq("t5_async_gnt", 32'(gnt), 32'd0);
    check_eq("t5_async_busy", 32'(busy), 32'd0);
    check_eq("t5_async_idx", 32'(char_idx), 32'd0);
    req = 2'b00;
    exp_bytes.delete();
    exp_lines.delete();
    model_prio = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_line(0);
    req = 2'b01;
    wait_first_send("t5");
    check_eq("t5_restart_cmd", 32'({lcd_ins_data, lcd_data}), 32'h080);
    wait_done("t5");
    req = 2'b00;
    repeat (5) @(negedge clk);

    // Request dropped after the third character
    do_reset();
    push_line(0);
    start = total_sends;
    req = 2'b01;
    wait_sends(start + 4, "t6");
    req = 2'b00;
    wait_done("t6");
    check_eq("t6_done_bit", 32'(done), 32'h1);
    repeat (5) @(negedge clk);
    check_eq("t6_send_total", total_sends - start, 17);

    check_eq("end_bytes_drained", exp_bytes.size(), 0);
    check_eq("end_lines_drained", exp_lines.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/lcd_line_scheduler.md
# lcd_line_scheduler

Sequencer and arbiter in front of `lcd_disp_interface`. It shares the single LCD write port between two line requesters: requester 0 owns LCD line 0 (time readout) and requester 1 owns line 1 (alarm/status text). For each grant it issues a DDRAM cursor instruction followed by `LINE_LEN` character writes, pacing every write on the interface's `ready` handshake. It replaces the ad-hoc `data_index`/`sendPulse` sequencing in the top level.

## Interface
Parameters:
- `LINE_LEN`, default 16: characters written per grant; legal range 1..16.
- `ADDR_LINE0`, default 8'h80: set-DDRAM instruction sent for requester 0.
- `ADDR_LINE1`, default 8'hC0: set-DDRAM instruction sent for requester 1.

Ports:
- `clk` input, 1: single clock; all state is on the rising edge.
- `rst` input, 1: reset, asynchronous and active-low.
- `req` input, 2: level request per requester; held high until the matching `done` pulse.
- `char_in0` input, 8: requester 0 character at `char_idx`; combinational from `char_idx`.
- `char_in1` input, 8: requester 1 character at `char_idx`.
- `char_idx` output, 4: character index being fetched.
- `gnt` output, 2: one-hot grant; held for the whole transfer.
- `done` output, 2: one-cycle pulse on the granted bit when its line completes.
- `busy` output, 1: high in every state except IDLE.
- `lcd_ready` input, 1: `ready` from `lcd_disp_interface`.
- `lcd_send` output, 1: `send_data` strobe to the interface.
- `lcd_ins_data` output, 1: drives RS; 0 = instruction, 1 = character.
- `lcd_data` output, 8: byte to the interface.

## Operation
- Reset values: state IDLE; `lcd_send`=0, `lcd_ins_data`=0, `lcd_data`=8'h00, `char_idx`=0, `gnt`=0, `done`=0, `busy`=0; RR pointer = requester 0.
- IDLE: if `req`≠0 and `lcd_ready`=1, arbitrate, register `gnt`, go to CMD. If `lcd_ready`=0, stay in IDLE.
- Arbitration:
  - Single request: grant that requester.
  - Both requesting: see Configuration.
- CMD: drive `lcd_data`=ADDR_LINEx, `lcd_ins_data`=0, `lcd_send`=1 for exactly one cycle, then go to WAIT_LO.
- WAIT_LO: wait for `lcd_ready`=0, then go to WAIT_HI.
- WAIT_HI: wait for `lcd_ready`=1.
  - After the CMD write: go to CHAR with `char_idx`=0.
  - After a character write with `char_idx`<LINE_LEN-1: increment `char_idx`, go to CHAR.
  - After the last character: go to DONE.
- CHAR: register the selected `char_inx` into `lcd_data`, set `lcd_ins_data`=1, pulse `lcd_send`=1 for one cycle, go to WAIT_LO.
- DONE: `done[g]`=1 for one cycle; clear `gnt` and `char_idx`; update the RR pointer; return to IDLE.
- A requester whose `req` is still high in the DONE cycle is not re-granted in that cycle. It is eligible from IDLE on the next cycle.
- A `req` drop mid-transfer is ignored; the line always completes.
- `lcd_data`/`lcd_ins_data` hold their last value until the next CMD/CHAR update.
- Asynchronous reset during any state: outputs return to reset values immediately; `lcd_send` never stays high.

## Timing
- `lcd_send` is high for exactly one cycle per byte.
- `lcd_data`, `lcd_ins_data` and `lcd_send` change on the same edge; the data is stable while `lcd_send` is high.
- `char_idx` is valid one cycle before the CHAR cycle samples `char_inx`. Requesters get one full cycle of combinational lookup.
- `req` seen in IDLE with `lcd_ready`=1 → `gnt` visible next cycle. `lcd_send` for CMD follows one cycle after that.
- One line = 1+LINE_LEN writes. Each write costs 1 send cycle + WAIT_LO + WAIT_HI.
- `done` fires one cycle after the last `lcd_ready` rise.

## Configuration
- `LCD_RR_ARB_EN` defined: round-robin. When both requesters are asking, grant the one not granted last; the pointer updates in DONE.
- `LCD_RR_ARB_EN` undefined: fixed priority, requester 0 wins. No pointer register is built.

## Structure
- Shared package `lcd_pkg`:
  - state enum (IDLE, CMD, WAIT_LO, WAIT_HI, CHAR, DONE);
  - LCD instruction constants (set-DDRAM base 8'h80, clear 8'h01);
  - `LCD_LINE_MAX`=16.
- Sub-module `lcd_line_arb`: two-input arbiter. It takes `req`, a last-grant pointer and an enable, and outputs the one-hot grant. This is where the `LCD_RR_ARB_EN` logic sits.

## Test plan
- Reset, `req`=2'b01, model `ready` drops 1 cycle after send and returns 10 cycles later, `char_in0`=8'h30+idx → writes 8'h80 (RS=0), then 8'h30..8'h3F (RS=1); `done`=2'b01 once.
- `req`=2'b11 held, `LCD_RR_ARB_EN` defined → line order 0,1,0,1; every line starts with 8'h80/8'hC0 as appropriate.
- `req`=2'b11 held, macro undefined → requester 0 is granted every time; requester 1 is never granted.
- `lcd_ready` held low 200 cycles with `req`=2'b10 → no `lcd_send`, `gnt`=0; `ready` rises → CMD 8'hC0 is issued.
- `rst` low during WAIT_HI of char 5 → `lcd_send`/`gnt`/`busy` go to 0 asynchronously; after release, a fresh request restarts at the CMD byte.
- `req[0]` dropped after the 3rd char → the full 16 characters are still sent, then `done[0]` pulses.
